conv2d_filter_param: RTL
========================

Name: conv2d_filter_param

Overview:
Parametrised KxK 2-D convolution engine for the image-filter datapath. It reads pixels from a single-port synchronous SRAM and streams out one saturated output pixel per image position in raster order. This generation adds several capabilities:
- generic kernel, image and data sizes
- a sliding window that reloads only one new column per step along a row
- selectable border mode (zero-pad or clamp-replicate)
- power-of-two normalisation shift
- out_valid/out_ready backpressure

Parameters:
K, 5, kernel edge (odd, >=3); R=(K-1)/2 is a derived constant
IMG_W, 256, image width in pixels
IMG_H, 256, image height in pixels
DATA_W, 8, pixel width (unsigned)
COEF_W, 8, coefficient width (signed two's complement)
SHIFT, 0, arithmetic right shift applied to the accumulator before saturation
ADDR_W, 16, SRAM address width (must be >= clog2(IMG_W*IMG_H))

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  1-cycle pulse; begins coefficient load + frame (ignored unless IDLE)
mode_clamp  in  1  border mode, sampled on start: 0 = zero-pad, 1 = clamp-replicate
fc_valid  in  1  coefficient strobe
fc  in  COEF_W  coefficient, row-major (dy outer, dx inner, dy=-R first)
working_pixel  in  DATA_W  SRAM read data, valid 1 cycle after en/addr
addr  out  ADDR_W  SRAM address = y*IMG_W + x
en  out  1  SRAM chip enable, high only on read-issue cycles
wen  out  1  SRAM write enable, active-low; held 1 (read-only block)
d  out  DATA_W  SRAM write data; held 0
out_pixel  out  DATA_W  filtered pixel
out_valid  out  1  out_pixel valid
out_ready  in  1  consumer accepts when out_valid & out_ready
out_x  out  clog2(IMG_W)  column of out_pixel
out_y  out  clog2(IMG_H)  row of out_pixel
busy  out  1  high in every state except IDLE
done  out  1  1-cycle pulse after the last pixel is accepted

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE
  - all outputs 0, except wen=1
  - coefficient array, window, accumulator and counters cleared
  - reset asserted mid-frame aborts immediately; no further reads or outputs
- States: IDLE -> COEF -> FILL -> MAC -> OUT -> (SLIDE | FILL | DONE); SLIDE -> MAC; DONE -> IDLE.
- IDLE:
  - start=1 latches mode_clamp, then goes to COEF.
  - start is ignored in every other state.
- COEF:
  - Each cycle with fc_valid=1 writes the next coefficient, index 0..K*K-1.
  - Leaves on the first cycle with fc_valid=0, or after K*K writes.
  - Unwritten coefficients are 0; strobes beyond K*K are ignored.
  - x=y=0 on exit.
- FILL (first pixel of each row): K*K+1 cycles.
  - Cycles 0..K*K-1 issue one read each (en=1), raster over dy,dx.
  - Each read is captured into the window one cycle after issue.
- SLIDE (x>0): K+1 cycles.
  - Window shifts one column left.
  - K reads fetch column x+R, dy=-R..R.
- Border handling:
  - Out-of-range coordinates issue the read at the clamped address, so timing is fixed.
  - Zero-pad mode stores 0 for those positions; clamp mode stores the returned data.
  - Clamp ranges: [0,IMG_W-1] in x, [0,IMG_H-1] in y.
- MAC: K*K cycles, one signed multiply-accumulate per cycle.
  - Pixels are zero-extended, coefficients sign-extended.
  - Accumulator width ACC_W = DATA_W+COEF_W+clog2(K*K)+1; no overflow is possible.
- OUT:
  - v = acc >>> SHIFT, then saturate: v<0 -> 0, v>2^DATA_W-1 -> 2^DATA_W-1, else v.
  - out_pixel, out_x and out_y are registered and held stable while out_valid=1 and out_ready=0.
  - No reads are issued during OUT.
  - Acceptance advances x.
  - At x=IMG_W-1: x=0 and y advances, next state FILL.
  - At the last pixel (IMG_W-1, IMG_H-1): next state DONE.
- DONE: done=1 for one cycle, then IDLE.
- Latency from entering FILL/SLIDE to out_valid, with out_ready tied high:
  - row start: 2*K*K+1 cycles
  - in-row: K+K*K+1 cycles
- Corner case IMG_W=1: every pixel uses FILL.

Decomposition:
- Shared package conv_pkg holds:
  - the state enum type
  - the BORDER_ZERO/BORDER_CLAMP constants
  - the ACC_W function
  - a saturate function (signed ACC_W -> unsigned DATA_W)
- One natural sub-module is conv_window_buf: the KxK register window with column-shift and indexed write/read, parametrised by K and DATA_W.

Test Plan:
- Bench parameters: IMG_W=IMG_H=8, default K=5, unless noted.
- Identity kernel (centre=1, others 0), ramp image pix=y*8+x -> every out_pixel equals its input; 64 outputs in raster order; done pulses once.
- All-ones kernel, constant-10 image, zero-pad -> (0,0)=90, (1,0)=120, (3,3)=250. Same with clamp -> all 250.
- Saturation: all-ones kernel on a 255 image -> 255. Kernel all -1 -> 0. SHIFT=2, centre=8, pix=20 -> 40.
- Backpressure: out_ready held 0 for 5 cycles on pixel (2,1) -> out_pixel/out_x/out_y stable, en=0 throughout, next read follows acceptance.
- Short coefficient stream: 3 strobes (1,2,3) then fc_valid=0 -> remaining 22 coefficients are 0. Output (2,2) on ramp = 1*pix(0,0)+2*pix(1,0)+3*pix(2,0) = 8.
- rst pulsed at pixel (4,2); start re-issued -> clean restart from (0,0) with fresh coefficients; no stale out_valid.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and helpers for the KxK convolution engine and its window buffer.
package conv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COEF,
        S_FILL,
        S_SLIDE,
        S_MAC,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic BORDER_ZERO  = 1'b0;
    localparam logic BORDER_CLAMP = 1'b1;

    // Index width that stays at least one bit for degenerate 1-pixel dimensions.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int acc_w(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps) + 1;
    endfunction

    function automatic logic [31:0] saturate(input logic signed [63:0] v, input int data_w);
        logic signed [63:0] vmax;
        vmax = (64'sd1 <<< data_w) - 64'sd1;
        if (v < 0) return '0;
        if (v > vmax) return vmax[31:0];
        return v[31:0];
    endfunction

endpackage

// File: rtl/conv_window_buf.sv
// KxK pixel window stored row-major; supports a whole-window column shift-left
// and single-entry indexed write/read.
module conv_window_buf #(
    parameter int  K      = 5,
    parameter int  DATA_W = 8,
    localparam int IW     = $clog2(K * K)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_i,
    input  logic              wr_en_i,
    input  logic [IW-1:0]     wr_idx_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [IW-1:0]     rd_idx_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] win_q [K*K];

    assign rd_data_o = win_q[rd_idx_i];

    // Shift and write never coincide: the first slide capture lands a cycle after the shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < K * K; i++) win_q[i] <= '0;
        end else if (shift_i) begin
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K - 1; c++)
                    win_q[r*K + c] <= win_q[r*K + c + 1];
        end else if (wr_en_i) begin
            win_q[wr_idx_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/conv2d_filter_param.sv
// KxK 2-D convolution engine: fetches pixels from a synchronous SRAM into a sliding
// window and streams one saturated result per pixel in raster order.
//   IDLE wait start | COEF load taps | FILL full window reload | SLIDE one new column
//   MAC  K*K multiply-accumulates | OUT hold result until accepted | DONE end-of-frame pulse
module conv2d_filter_param
    import conv_pkg::*;
#(
    parameter int K      = 5,
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int SHIFT  = 0,
    parameter int ADDR_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     mode_clamp,
    input  logic                     fc_valid,
    input  logic signed [COEF_W-1:0] fc,
    input  logic [DATA_W-1:0]        working_pixel,
    output logic [ADDR_W-1:0]        addr,
    output logic                     en,
    output logic                     wen,
    output logic [DATA_W-1:0]        d,
    output logic [DATA_W-1:0]        out_pixel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [idx_w(IMG_W)-1:0]  out_x,
    output logic [idx_w(IMG_H)-1:0]  out_y,
    output logic                     busy,
    output logic                     done
);

    localparam int R     = (K - 1) / 2;
    localparam int TAPS  = K * K;
    localparam int ACC_W = acc_w(DATA_W, COEF_W, TAPS);
    localparam int XW    = idx_w(IMG_W);
    localparam int YW    = idx_w(IMG_H);
    localparam int CW    = $clog2(TAPS + 1);
    localparam int RW    = $clog2(K);
    localparam int IW    = $clog2(TAPS);

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [XW-1:0]           x_q, x_d, out_x_q, out_x_d;
    logic [YW-1:0]           y_q, y_d, out_y_q, out_y_d;
    logic [RW-1:0]           iss_r_q, iss_r_d, iss_c_q, iss_c_d;
    logic                    clamp_q, clamp_d, oob_q, oob_d;
    logic                    cap_valid_q, cap_valid_d, cap_zero_q, cap_zero_d;
    logic [IW-1:0]           cap_idx_q, cap_idx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, acc_sh, prod;
    logic                    en_q, en_d, out_valid_q, out_valid_d;
    logic                    busy_q, busy_d, done_q, done_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       out_pixel_q, out_pixel_d, win_rd;
    logic                    coef_clr, coef_we;
    logic signed [COEF_W-1:0] coef_q [TAPS];
    int                      px, py, cx, cy;

    conv_window_buf #(.K(K), .DATA_W(DATA_W)) u_win (
        .clk       (clk),
        .rst       (rst),
        .shift_i   (state_q == S_SLIDE && cnt_q == '0),
        .wr_en_i   (cap_valid_q),
        .wr_idx_i  (cap_idx_q),
        .wr_data_i (cap_zero_q ? '0 : working_pixel),
        .rd_idx_i  (IW'(cnt_q)),
        .rd_data_o (win_rd)
    );

    assign prod = signed'(ACC_W'(win_rd)) * ACC_W'(coef_q[IW'(cnt_q)]);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        iss_r_d     = iss_r_q;
        iss_c_d     = iss_c_q;
        clamp_d     = clamp_q;
        acc_d       = acc_q;
        acc_sh      = '0;
        en_d        = 1'b0;
        out_valid_d = out_valid_q;
        out_pixel_d = out_pixel_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        coef_clr    = 1'b0;
        coef_we     = 1'b0;

        case (state_q)
            S_IDLE: if (start) begin
                clamp_d  = mode_clamp ? BORDER_CLAMP : BORDER_ZERO;
                coef_clr = 1'b1;
                cnt_d    = '0;
                state_d  = S_COEF;
            end
            S_COEF: begin
                if (fc_valid) begin
                    coef_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
                if (!fc_valid || cnt_q == CW'(TAPS - 1)) begin
                    state_d = S_FILL;
                    cnt_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                    iss_r_d = '0;
                    iss_c_d = '0;
                    en_d    = 1'b1;
                end
            end
            S_FILL: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q < CW'(TAPS - 1)) begin
                    en_d = 1'b1;
                    if (iss_c_q == RW'(K - 1)) begin
                        iss_c_d = '0;
                        iss_r_d = iss_r_q + 1'b1;
                    end else begin
                        iss_c_d = iss_c_q + 1'b1;
                    end
                end else if (cnt_q == CW'(TAPS)) begin
                    state_d = S_MAC;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            S_SLIDE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q < CW'(K - 1)) begin
                    en_d    = 1'b1;
                    iss_r_d = iss_r_q + 1'b1;
                end else if (cnt_q == CW'(K)) begin
                    state_d = S_MAC;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            S_MAC: begin
                acc_d = acc_q + prod;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(TAPS - 1)) begin
                    acc_sh      = acc_d >>> SHIFT;
                    out_pixel_d = DATA_W'(saturate(64'(acc_sh), DATA_W));
                    out_valid_d = 1'b1;
                    out_x_d     = x_q;
                    out_y_d     = y_q;
                    state_d     = S_OUT;
                end
            end
            S_OUT: if (out_ready) begin
                out_valid_d = 1'b0;
                cnt_d       = '0;
                iss_r_d     = '0;
                en_d        = 1'b1;
                if (x_q == XW'(IMG_W - 1)) begin
                    x_d     = '0;
                    iss_c_d = '0;
                    if (y_q == YW'(IMG_H - 1)) begin
                        state_d = S_DONE;
                        en_d    = 1'b0;
                    end else begin
                        y_d     = y_q + 1'b1;
                        state_d = S_FILL;
                    end
                end else begin
                    x_d     = x_q + 1'b1;
                    iss_c_d = RW'(K - 1);
                    state_d = S_SLIDE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Out-of-range taps still read the clamped address so fetch timing never varies.
        px          = int'(x_d) + int'(iss_c_d) - R;
        py          = int'(y_d) + int'(iss_r_d) - R;
        cx          = (px < 0) ? 0 : ((px > IMG_W - 1) ? IMG_W - 1 : px);
        cy          = (py < 0) ? 0 : ((py > IMG_H - 1) ? IMG_H - 1 : py);
        oob_d       = en_d && (px != cx || py != cy);
        addr_d      = en_d ? ADDR_W'(cy * IMG_W + cx) : '0;
        cap_valid_d = en_q;
        cap_idx_d   = IW'(int'(iss_r_q) * K + int'(iss_c_q));
        cap_zero_d  = oob_q && (clamp_q != BORDER_CLAMP);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            iss_r_q     <= '0;
            iss_c_q     <= '0;
            clamp_q     <= 1'b0;
            oob_q       <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_zero_q  <= 1'b0;
            cap_idx_q   <= '0;
            acc_q       <= '0;
            en_q        <= 1'b0;
            addr_q      <= '0;
            out_valid_q <= 1'b0;
            out_pixel_q <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < TAPS; i++) coef_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            iss_r_q     <= iss_r_d;
            iss_c_q     <= iss_c_d;
            clamp_q     <= clamp_d;
            oob_q       <= oob_d;
            cap_valid_q <= cap_valid_d;
            cap_zero_q  <= cap_zero_d;
            cap_idx_q   <= cap_idx_d;
            acc_q       <= acc_d;
            en_q        <= en_d;
            addr_q      <= addr_d;
            out_valid_q <= out_valid_d;
            out_pixel_q <= out_pixel_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            if (coef_clr) begin
                for (int i = 0; i < TAPS; i++) coef_q[i] <= '0;
            end else if (coef_we) begin
                coef_q[IW'(cnt_q)] <= fc;
            end
        end
    end

    assign addr      = addr_q;
    assign en        = en_q;
    assign wen       = 1'b1;
    assign d         = '0;
    assign out_pixel = out_pixel_q;
    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
